// File: rtl/voice_scheduler_if.sv
// DAC-side strobe/sample signals plus the shared sine ROM port of voice_scheduler.
interface voice_scheduler_if;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] sample_out;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;

    modport master (
        input  audio_out_allowed,
        input  rom_data,
        output write_audio_out,
        output sample_out,
        output rom_addr
    );

    modport slave (
        output audio_out_allowed,
        output rom_data,
        input  write_audio_out,
        input  sample_out,
        input  rom_addr
    );
endinterface

// File: rtl/voice_scheduler.sv
// Polyphonic key-to-voice scheduler sharing one sine ROM across all voices per sample.
// Optional `VOICE_STEAL_EN: oldest active voice is reassigned when no voice is free.
module voice_scheduler #(
    parameter int NUM_KEYS   = 10,
    parameter int NUM_VOICES = 4,
    parameter int VOL_SHIFT  = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [NUM_KEYS-1:0]   key_down,
    voice_scheduler_if.master     bus,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  busy
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int AW = 16 + VW;
    localparam int CW = VW + 1;
    localparam logic signed [AW-1:0] SAT_HI = AW'(32767);
    localparam logic signed [AW-1:0] SAT_LO = AW'(-32768);

    typedef enum logic [1:0] {IDLE, ALLOC, ACCUM, WRITE} state_t;

    function automatic logic [31:0] note_inc(input int unsigned k);
        case (k)
            0: return 32'd23410256;
            1: return 32'd26276252;
            2: return 32'd29494793;
            3: return 32'd31248571;
            4: return 32'd35075566;
            5: return 32'd39370534;
            6: return 32'd44191634;
            7: return 32'd46819617;
            8: return 32'd52553399;
            9: return 32'd58988691;
            default: return '0;
        endcase
    endfunction

    state_t                state;
    logic [NUM_KEYS-1:0]   key_meta, key_sync;
    logic [KW-1:0]         key_of   [NUM_VOICES];
    logic [31:0]           phase    [NUM_VOICES];
    logic [31:0]           inc      [NUM_VOICES];
    logic signed [AW-1:0]  acc, acc_next, term, shifted;
    logic [CW-1:0]         idx;
    logic [VW-1:0]         prev;
    logic [15:0]           sat16;

    logic [NUM_VOICES-1:0] al_active;
    logic [KW-1:0]         al_key   [NUM_VOICES];
    logic [31:0]           al_phase [NUM_VOICES];
    logic [31:0]           al_inc   [NUM_VOICES];
    logic                  held, found;
    logic [VW-1:0]         slot;
`ifdef VOICE_STEAL_EN
    logic [VW-1:0]         age      [NUM_VOICES];
    logic [VW-1:0]         al_age   [NUM_VOICES];
    logic [VW-1:0]         oldest;
    logic                  stolen;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            key_meta <= key_down;
            key_sync <= key_meta;
        end
    end

    // Release pass first, then ascending-key allocation into the lowest free voice.
    always_comb begin
        al_active = voice_active;
        al_key    = key_of;
        al_phase  = phase;
        al_inc    = inc;
        held      = 1'b0;
        found     = 1'b0;
        slot      = '0;
`ifdef VOICE_STEAL_EN
        al_age    = age;
        oldest    = '0;
        stolen    = 1'b0;
`endif
        for (int unsigned v = 0; v < NUM_VOICES; v++)
            if (al_active[v] && !key_sync[al_key[v]]) al_active[v] = 1'b0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            held  = 1'b0;
            found = 1'b0;
            slot  = '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++)
                if (al_active[v] && al_key[v] == KW'(k)) held = 1'b1;
            if (key_sync[k] && !held) begin
                for (int unsigned v = 0; v < NUM_VOICES; v++)
                    if (!found && !al_active[v]) begin
                        found = 1'b1;
                        slot  = VW'(v);
                    end
`ifdef VOICE_STEAL_EN
                if (!found && !stolen) begin
                    oldest = '0;
                    for (int unsigned v = 0; v < NUM_VOICES; v++)
                        if (al_age[v] > al_age[oldest]) oldest = VW'(v);
                    slot   = oldest;
                    found  = 1'b1;
                    stolen = 1'b1;
                end
`endif
                if (found) begin
                    al_active[slot] = 1'b1;
                    al_key[slot]    = KW'(k);
                    al_phase[slot]  = '0;
                    al_inc[slot]    = note_inc(k);
`ifdef VOICE_STEAL_EN
                    for (int unsigned v = 0; v < NUM_VOICES; v++)
                        if (VW'(v) != slot && al_age[v] != VW'(NUM_VOICES - 1))
                            al_age[v] = al_age[v] + 1'b1;
                    al_age[slot] = '0;
`endif
                end
            end
        end
    end

    assign prev     = VW'(idx - 1'b1);
    assign term     = voice_active[prev] ? {{(AW-16){bus.rom_data[15]}}, bus.rom_data} : '0;
    assign acc_next = acc + term;
    assign shifted  = acc_next >>> VOL_SHIFT;

    always_comb begin
        if (shifted > SAT_HI)      sat16 = 16'h7FFF;
        else if (shifted < SAT_LO) sat16 = 16'h8000;
        else                       sat16 = shifted[15:0];
    end

    // ROM address runs one voice ahead of the accumulate/advance stage.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state               <= IDLE;
            busy                <= 1'b0;
            bus.write_audio_out <= 1'b0;
            bus.sample_out      <= '0;
            bus.rom_addr        <= '0;
            voice_active        <= '0;
            acc                 <= '0;
            idx                 <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                key_of[v] <= '0;
                phase[v]  <= '0;
                inc[v]    <= '0;
`ifdef VOICE_STEAL_EN
                age[v]    <= '0;
`endif
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.audio_out_allowed) begin
                        state <= ALLOC;
                        busy  <= 1'b1;
                    end
                end
                ALLOC: begin
                    voice_active <= al_active;
                    key_of       <= al_key;
                    phase        <= al_phase;
                    inc          <= al_inc;
`ifdef VOICE_STEAL_EN
                    age          <= al_age;
`endif
                    acc          <= '0;
                    idx          <= '0;
                    bus.rom_addr <= al_phase[0][31:24];
                    state        <= ACCUM;
                end
                ACCUM: begin
                    if (idx != '0) begin
                        acc <= acc_next;
                        if (voice_active[prev]) phase[prev] <= phase[prev] + inc[prev];
                    end
                    if (idx < CW'(NUM_VOICES - 1))
                        bus.rom_addr <= phase[VW'(idx + 1'b1)][31:24];
                    else
                        bus.rom_addr <= '0;
                    if (idx == CW'(NUM_VOICES)) begin
                        bus.sample_out      <= {sat16, 16'h0000};
                        bus.write_audio_out <= bus.audio_out_allowed;
                        state               <= WRITE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.write_audio_out) begin
                        bus.write_audio_out <= 1'b0;
                        busy                <= 1'b0;
                        state               <= IDLE;
                    end else begin
                        bus.write_audio_out <= bus.audio_out_allowed;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
